data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests. It latches one request, holds the pipeline with `stall_o` for a fixed number of cycles, then commits the write or returns the read word with a one-cycle `ack_o`. It replaces the single-cycle data memory. `stall_o` feeds the hazard unit, which freezes the PC and all pipeline registers.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; must be ≥2.
- `LATENCY`, 4: cycles from request acceptance to `ack_o`; must be ≥1.

- `clk_i` in 1: the design clock.
- `rst_i` in 1: one clock; reset is synchronous and active-high.
- `req_i` in 1: access request from the MEM stage (MemRead | MemWrite).
- `we_i` in 1: 1 = store, 0 = load; sampled with `req_i`.
- `addr_i` in 32: byte address; word index is `addr_i[31:2]`.
- `wdata_i` in 32: store data; sampled with `req_i`.
- `rdata_o` out 32: load data; registered; stable from `ack_o` until the next completion.
- `stall_o` out 1: the pipeline must hold while this is high.
- `ack_o` out 1: one-cycle completion pulse.
- `err_o` out 1: high together with `ack_o` when the completed request was illegal.

## Operation
- States:
  - IDLE: no request in progress.
  - BUSY: latency count running.
  - DONE: response cycle.
- IDLE with `req_i`=1: accept the request.
  - Latch `we`, the word index, `wdata`, and `bad`.
  - `bad` = (`addr_i[1:0]` ≠ 0) or (`addr_i[31:2]` ≥ DEPTH_WORDS).
  - Load counter with LATENCY−1.
  - If LATENCY=1, go to DONE and commit on this edge; otherwise go to BUSY.
- BUSY:
  - If counter=1, commit and go to DONE.
  - Otherwise decrement the counter.
  - `req_i` is ignored.
- Commit (same edge as entry to DONE):
  - Store, not `bad`: write the latched data to mem[index]. `rdata_o` is unchanged.
  - Load, not `bad`: `rdata_o` ← mem[index].
  - `bad`: no write; `rdata_o` ← 0; the error flag is set.
- DONE:
  - `ack_o`=1; `err_o`=error flag; `stall_o`=0.
  - `req_i` is ignored; the same request still sits in EX/MEM and must not be re-accepted.
  - Next state is always IDLE.
- `stall_o` = (IDLE & `req_i`) | BUSY; it is forced to 0 while `rst_i`=1.
- The memory array is not cleared by reset. The bench initializes memory through stores.
- Reset (any state, including mid-operation):
  - Next state IDLE.
  - Pending write is discarded.
  - Counter is cleared.
- Simultaneous `rst_i` and an accepting edge with LATENCY=1: reset wins, and no write occurs.

## Timing
- Request accepted in cycle T (IDLE, `req_i`=1):
  - `stall_o`=1 in cycles T … T+LATENCY−1, which is exactly LATENCY stall cycles.
  - `ack_o`=1 and `rdata_o` valid in cycle T+LATENCY.
  - The pipeline advances at the end of cycle T+LATENCY.
- Earliest next acceptance is cycle T+LATENCY+1, giving throughput of one access per LATENCY+1 cycles.
- A store that acks at T+LATENCY is visible to a load accepted at T+LATENCY+1.
- Reset values:
  - `rdata_o`=0, `ack_o`=0, `err_o`=0.
  - `stall_o`=0 while `rst_i` is high, and in the first post-reset cycle unless `req_i`=1.
  - State IDLE.
- `ack_o` and `err_o` are never high for more than one consecutive cycle.

## Test plan
- **Store then load, LATENCY=4:**
  - Store 0xDEADBEEF to address 0x10 at T.
  - Required: `stall_o` high T…T+3, `ack_o` at T+4, `err_o`=0.
  - Then load 0x10 at T+5.
  - Required: `ack_o` at T+9 with `rdata_o`=0xDEADBEEF, held stable until the next ack.
- **Held request:**
  - Hold `req_i`=1 with the same load through the DONE cycle, then drop it.
  - Required: exactly one `ack_o`; no second stall sequence starts in the DONE cycle.
- **Illegal addresses:**
  - Load 0x13 (misaligned).
  - Required: ack at T+4, `err_o`=1, `rdata_o`=0.
  - Store to byte address 4·DEPTH_WORDS.
  - Required: `err_o`=1; a later load of word 0 is unchanged.
- **Reset mid-operation:**
  - Store 0x12345678 to 0x20; assert `rst_i` at T+2.
  - Required: `stall_o`=0 and `ack_o` never pulses.
  - A later load of 0x20 returns the pre-reset contents, not 0x12345678.
- **LATENCY=1 build:**
  - Issue back-to-back store/load to 0x4.
  - Required: one stall cycle each, ack at T+1, load acked at T+3 returns the stored word.
- **Back-to-back loads, LATENCY=4:**
  - Issue loads to 0x0 and 0x8 (previously stored 1 and 2).
  - Required: acks at T+4 and T+9 with `rdata_o`=1 and `rdata_o`=2 respectively.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for the MEM stage; latches one
// load/store, stalls the pipeline LATENCY cycles, then acks (err on illegal).
// Ports: clk_i, rst_i (sync, active-high), req_i/we_i/addr_i/wdata_i request,
//        rdata_o load data, stall_o to hazard unit, ack_o/err_o completion.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            bad_q, bad_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            ack_q, ack_d;
   logic            err_q, err_d;

   logic [31:0]     mem [DEPTH_WORDS];

   logic            req_bad;
   logic            commit;
   logic            c_we;
   logic [IW-1:0]   c_idx;
   logic [31:0]     c_wdata;
   logic            c_bad;
   logic            mem_we;

   always_comb begin
      req_bad = (addr_i[1:0] != 2'b00) ||
                ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));

      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      bad_d   = bad_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;

      commit  = 1'b0;
      c_we    = we_q;
      c_idx   = idx_q;
      c_wdata = wdata_q;
      c_bad   = bad_q;

      unique case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               idx_d   = addr_i[IW+1:2];
               wdata_d = wdata_i;
               bad_d   = req_bad;
               cnt_d   = CW'(LATENCY - 1);
               if (LATENCY == 1) begin
                  // Single-cycle build commits straight from the request.
                  state_d = DONE;
                  commit  = 1'b1;
                  c_we    = we_i;
                  c_idx   = addr_i[IW+1:2];
                  c_wdata = wdata_i;
                  c_bad   = req_bad;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == CW'(1)) begin
               commit  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            // Request is still held in EX/MEM here; never re-accept it.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit) begin
         ack_d = 1'b1;
         err_d = c_bad;
         if (c_bad) begin
            rdata_d = '0;
         end else if (!c_we) begin
            rdata_d = mem[c_idx];
         end
      end
   end

   // A reset on the commit edge discards the write.
   assign mem_we = commit && c_we && !c_bad && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         bad_q   <= 1'b0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         bad_q   <= bad_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Array has no reset; contents survive a pipeline reset.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[c_idx] <= c_wdata;
      end
   end

   assign stall_o = !rst_i &&
                    (((state_q == IDLE) && req_i) || (state_q == BUSY));
   assign rdata_o = rdata_q;
   assign ack_o   = ack_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized + directed bench for data_mem_responder,
// one instance with LATENCY=4 and one with LATENCY=1, transaction-level model.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4, req4, we4, st4, ack4, err4;
   logic [31:0] addr4, wd4, rd4;
   logic        rst1, req1, we1, st1, ack1, err1;
   logic [31:0] addr1, wd1, rd1;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
      .clk_i(clk), .rst_i(rst4), .req_i(req4), .we_i(we4),
      .addr_i(addr4), .wdata_i(wd4), .rdata_o(rd4),
      .stall_o(st4), .ack_o(ack4), .err_o(err4)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1),
      .addr_i(addr1), .wdata_i(wd1), .rdata_o(rd1),
      .stall_o(st1), .ack_o(ack1), .err_o(err1)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Model: word array and last-returned read data, per instance.
   logic [31:0] mem_m [2][256];
   logic [31:0] rd_m  [2];

   initial begin
      #5000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input bit l1, input logic rq, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
      if (l1) begin
         req1 = rq; we1 = we; addr1 = a; wd1 = d;
      end else begin
         req4 = rq; we4 = we; addr4 = a; wd4 = d;
      end
   endtask

   task automatic peek(input bit l1, output logic s, output logic a,
                       output logic e, output logic [31:0] r);
      s = l1 ? st1 : st4;
      a = l1 ? ack1 : ack4;
      e = l1 ? err1 : err4;
      r = l1 ? rd1 : rd4;
   endtask

   // One request held through its DONE cycle, checked every cycle.
   task automatic access(input bit l1, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
      int lat;
      bit bad;
      int idx;
      logic s, a, e;
      logic [31:0] r;
      lat = l1 ? 1 : 4;
      bad = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
      idx = int'(addr[9:2]);
      drive(l1, 1'b1, we, addr, wd);
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat) begin
            if (bad) rd_m[l1] = 32'h0;
            else if (we) mem_m[l1][idx] = wd;
            else rd_m[l1] = mem_m[l1][idx];
         end
         peek(l1, s, a, e, r);
         n_total++;
         if (s !== (c < lat)) begin
            n_bad++;
            $display("FAIL stall lat%0d a=%h c=%0d: got %b want %b",
                     lat, addr, c, s, (c < lat));
         end
         n_total++;
         if ({a, e} !== {c == lat, (c == lat) && bad}) begin
            n_bad++;
            $display("FAIL ack_err lat%0d a=%h c=%0d: got %b%b want %b%b",
                     lat, addr, c, a, e, c == lat, (c == lat) && bad);
         end
         n_total++;
         if (r !== rd_m[l1]) begin
            n_bad++;
            $display("FAIL rdata lat%0d a=%h c=%0d: got %h want %h",
                     lat, addr, c, r, rd_m[l1]);
         end
         @(posedge clk);
         #1;
      end
      drive(l1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic idle(input bit l1, input int n);
      logic s, a, e;
      logic [31:0] r;
      drive(l1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         peek(l1, s, a, e, r);
         n_total++;
         if ({s, a, e} !== 3'b000 || r !== rd_m[l1]) begin
            n_bad++;
            $display("FAIL idle l1=%0d i=%0d: got s/a/e=%b%b%b rd=%h want 000 rd=%h",
                     l1, i, s, a, e, r, rd_m[l1]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst4 = 1'b1; rst1 = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h55);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      rd_m[0] = 32'h0;
      rd_m[1] = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_total++;
         if ({st4, ack4, err4} !== 3'b000 || rd4 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset4: got s/a/e=%b%b%b rd=%h want 000 rd=0",
                     st4, ack4, err4, rd4);
         end
         n_total++;
         if ({st1, ack1, err1} !== 3'b000 || rd1 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset1: got s/a/e=%b%b%b rd=%h want 000 rd=0",
                     st1, ack1, err1, rd1);
         end
         @(posedge clk);
         #1;
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst4 = 1'b0; rst1 = 1'b0;
      idle(1'b0, 2);
      idle(1'b1, 2);
   endtask

   task automatic test_store_load();
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      access(1'b0, 1'b0, 32'h10, 32'h0);
      idle(1'b0, 3);
   endtask

   task automatic test_illegal();
      access(1'b0, 1'b1, 32'h0, 32'hA5A5_0000);
      access(1'b0, 1'b0, 32'h0, 32'h0);
      access(1'b0, 1'b0, 32'h13, 32'h0);
      access(1'b0, 1'b1, 32'd1024, 32'hFFFF_FFFF);
      access(1'b0, 1'b1, 32'h2, 32'h1234_0002);
      access(1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b0, 1);
   endtask

   task automatic test_back_to_back();
      access(1'b0, 1'b1, 32'h0, 32'h1);
      access(1'b0, 1'b1, 32'h8, 32'h2);
      access(1'b0, 1'b0, 32'h0, 32'h0);
      access(1'b0, 1'b0, 32'h8, 32'h0);
      idle(1'b0, 1);
   endtask

   task automatic test_reset_mid();
      access(1'b0, 1'b1, 32'h20, 32'hCAFE_0020);
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
      for (int c = 0; c < 3; c++) begin
         if (c == 2) rst4 = 1'b1;
         @(negedge clk);
         n_total++;
         if (st4 !== (c < 2) || ack4 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid c=%0d: got s=%b a=%b want s=%b a=0",
                     c, st4, ack4, (c < 2));
         end
         @(posedge clk);
         #1;
      end
      rst4 = 1'b0;
      rd_m[0] = 32'h0;
      idle(1'b0, 6);
      access(1'b0, 1'b0, 32'h20, 32'h0);
   endtask

   task automatic test_lat1();
      access(1'b1, 1'b1, 32'h4, 32'h0BAD_F00D);
      access(1'b1, 1'b0, 32'h4, 32'h0);
      idle(1'b1, 1);
      rst1 = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 32'h4, 32'h1111_1111);
      @(negedge clk);
      n_total++;
      if ({st1, ack1} !== 2'b00) begin
         n_bad++;
         $display("FAIL lat1_rst_accept: got s/a=%b%b want 00", st1, ack1);
      end
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      rd_m[1] = 32'h0;
      idle(1'b1, 2);
      access(1'b1, 1'b0, 32'h4, 32'h0);
      access(1'b1, 1'b0, 32'h7, 32'h0);
      idle(1'b1, 1);
   endtask

   task automatic test_random(input bit l1, input int n);
      logic [31:0] a;
      int k;
      for (int i = 0; i < 16; i++) begin
         access(l1, 1'b1, 32'(i * 4), $urandom);
      end
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin
            a = $urandom;
            a[1:0] = 2'($urandom_range(1, 3));
         end else if (k == 1) begin
            a = 32'd1024 + 32'($urandom_range(0, 4000)) * 4;
         end else begin
            a = 32'($urandom_range(0, 15)) * 4;
         end
         access(l1, 1'($urandom_range(0, 1)), a, $urandom);
         if ($urandom_range(0, 3) == 0) idle(l1, $urandom_range(1, 3));
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_store_load();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_lat1();
      test_random(1'b0, 40);
      test_random(1'b1, 40);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
